opend_flag_collector: RTL

//  Parametrised operand-done flag collector for the memory controller. Latches
//  per-core operand-done pulses into sticky flags and issues a one-cycle

---
 rtl/opend_flag_collector.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/opend_flag_collector.sv
// rtl/opend_flag_collector.sv - operand-done flag collector with one-cycle completion pulse
//
// Latches per-core operand-done pulses into sticky flags and pulses
// state_ctrl_signal once the completion condition holds (MODE 0: all masked
// cores done, MODE 1: any masked core done). It then waits for ack, clears the
// flags and re-arms. Optional collection timeout when OPEND_TIMEOUT_EN is defined.
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   op_done           per-core operand-done level, sampled each clk
//   core_mask         1 = core participates in this collection
//   ack               controller has consumed state_ctrl_signal (honoured in WAIT_ACK only)
//   state_ctrl_signal one-cycle completion pulse (registered from the FIRE state)
//   done_vec          sticky flags collected so far
//   busy              high while in COLLECT, FIRE or WAIT_ACK
//   overrun           sticky: op_done seen while in FIRE/WAIT_ACK, cleared only by rst
//   timeout           one-cycle pulse on collection timeout (tied 0 without OPEND_TIMEOUT_EN)

module opend_flag_collector #(
  parameter int NUM_CORES      = 4,
  parameter int MODE           = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] op_done,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic                 ack,
  output logic                 state_ctrl_signal,
  output logic [NUM_CORES-1:0] done_vec,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_FIRE     = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [NUM_CORES-1:0] hit, nxt, done_vec_nxt;
  logic                 done;
  logic                 timeout_hit;
  logic                 timeout_nxt;
  logic                 in_hold;

  assign hit     = op_done & core_mask;
  assign nxt     = done_vec | hit;
  assign in_hold = (state == S_FIRE) || (state == S_WAIT_ACK);

  // Completion is judged against the live mask, so dropping mask bits during
  // a collection can complete it.
  always_comb begin
    done = 1'b0;
    if (MODE == 0)
      done = (core_mask != '0) && ((nxt & core_mask) == core_mask);
    else
      done = ((nxt & core_mask) != '0);
  end

`ifdef OPEND_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          cnt_clr;

  // to_cnt holds the number of COLLECT cycles already completed; the cycle
  // that would bring it to TIMEOUT_CYCLES is the timing-out one.
  assign timeout_hit = (state == S_COLLECT) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (cnt_clr)
      to_cnt <= '0;
    else if (state == S_COLLECT)
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    done_vec_nxt = done_vec;
    timeout_nxt  = 1'b0;
`ifdef OPEND_TIMEOUT_EN
    cnt_clr      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (hit != '0) begin
          done_vec_nxt = nxt;
          if (done) begin
            state_nxt = S_FIRE;
          end else begin
            state_nxt = S_COLLECT;
`ifdef OPEND_TIMEOUT_EN
            cnt_clr   = 1'b1;
`endif
          end
        end
      end
      S_COLLECT: begin
        done_vec_nxt = nxt;
        // done has priority over a coincident timeout
        if (done) begin
          state_nxt = S_FIRE;
        end else if (timeout_hit) begin
          done_vec_nxt = '0;
          timeout_nxt  = 1'b1;
          state_nxt    = S_IDLE;
        end
      end
      S_FIRE: begin
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack) begin
          done_vec_nxt = '0;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      done_vec          <= '0;
      state_ctrl_signal <= 1'b0;
      busy              <= 1'b0;
      overrun           <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      state             <= state_nxt;
      done_vec          <= done_vec_nxt;
      state_ctrl_signal <= (state == S_FIRE);
      busy              <= (state_nxt != S_IDLE);
      overrun           <= overrun | (in_hold && (op_done != '0));
      timeout           <= timeout_nxt;
    end
  end

endmodule
